// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit -- fetch-stage program counter
//
// Produces the instruction fetch address on its own. After reset it sits in
// BOOT for BOOT_CYCLES edges, holding RESET_VECTOR. In RUN it steps
// sequentially by INC, or takes the highest-priority redirect. Redirect
// sources are trap, trap return, jump and branch. In HALT it freezes until
// resume or trap.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   When defined, a jump/branch/trap_ret target that is not INC-aligned is
//   replaced by a trap entry. misalign then pulses high for one cycle.
//   When undefined, targets load unmodified and misalign is tied low.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   stall          in   hold pc instead of sequential increment
//   branch_taken   in   redirect to branch_target
//   branch_target  in   [XLEN] branch destination
//   jump           in   redirect to jump_target
//   jump_target    in   [XLEN] jump destination
//   trap           in   trap entry request (epc <= pc_out, pc <= TRAP_VECTOR)
//   trap_ret       in   return from trap to epc
//   halt_req       in   request HALT
//   resume         in   leave HALT
//   pc_out         out  [XLEN] registered fetch address
//   pc_next        out  [XLEN] value pc_out loads at the next edge
//   pc_valid       out  pc_out is a valid fetch address (state == RUN)
//   epc            out  [XLEN] saved exception pc
//   state          out  [2] BOOT=0, RUN=1, HALT=2
//   misalign       out  one-cycle misaligned-target flag
// ============================================================================
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              INC          = 4,
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic            trap_ret,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic [1:0]      state,
    output logic            misalign
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Wide enough to count up to BOOT_CYCLES.
    localparam int BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic [BW-1:0]   r_boot_cnt;
    logic            r_misalign;

    state_t          w_state_next;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_epc_next;
    logic [BW-1:0]   w_boot_next;
    logic            w_misalign_next;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_target_bad;

    // Winning redirect target among trap_ret > jump > branch. Trap itself
    // is handled separately because it also saves epc.
    always_comb begin
        w_redirect = trap_ret | jump | branch_taken;
        if (trap_ret)
            w_target = r_epc;
        else if (jump)
            w_target = jump_target;
        else
            w_target = branch_target;
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    assign w_target_bad = |(w_target & ALIGN_MASK);
`else
    assign w_target_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register (and datapath registers sharing its reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_boot_cnt <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_epc      <= w_epc_next;
            r_boot_cnt <= w_boot_next;
            r_misalign <= w_misalign_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-pc logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_epc_next      = r_epc;
        w_boot_next     = r_boot_cnt;
        w_misalign_next = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_pc_next   = RESET_VECTOR;
                w_boot_next = r_boot_cnt + 1'b1;
                if (r_boot_cnt == BOOT_LAST)
                    w_state_next = ST_RUN;
            end

            ST_RUN: begin
                if (trap) begin
                    w_epc_next = r_pc;
                    w_pc_next  = TRAP_VECTOR;
                end else if (w_redirect) begin
                    if (w_target_bad) begin
                        // Misaligned target becomes a trap entry instead.
                        w_epc_next      = r_pc;
                        w_pc_next       = TRAP_VECTOR;
                        w_misalign_next = 1'b1;
                    end else begin
                        w_pc_next = w_target;
                    end
                end else if (halt_req) begin
                    w_state_next = ST_HALT;
                end else if (!stall) begin
                    // Wraps modulo 2^XLEN.
                    w_pc_next = r_pc + XLEN'(INC);
                end
            end

            ST_HALT: begin
                if (trap) begin
                    w_epc_next   = r_pc;
                    w_pc_next    = TRAP_VECTOR;
                    w_state_next = ST_RUN;
                end else if (resume) begin
                    w_state_next = ST_RUN;
                end
            end

            default: begin
                // Unreachable encoding: fall back into BOOT.
                w_state_next = ST_BOOT;
                w_pc_next    = RESET_VECTOR;
                w_boot_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_out   = r_pc;
        pc_next  = w_pc_next;
        pc_valid = (r_state == ST_RUN);
        epc      = r_epc;
        state    = r_state;
        misalign = r_misalign;
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] TV  = 32'h0000_0100;
    localparam int          INC = 4;
    localparam int          BOOT_CYCLES = 2;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic        trap = 1'b0, trap_ret = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic [31:0] pc_out, pc_next, epc;
    logic        pc_valid, misalign;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .trap(trap), .trap_ret(trap_ret),
        .halt_req(halt_req), .resume(resume),
        .pc_out(pc_out), .pc_next(pc_next), .pc_valid(pc_valid),
        .epc(epc), .state(state), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode: 0 boot, 1 run, 2 halt. Boot is tracked as "edges remaining".
    int          m_mode = 0;
    int          m_boot_left = BOOT_CYCLES;
    logic [31:0] m_pc = RV;
    logic [31:0] m_epc = '0;
    bit          m_mis = 1'b0;

    task automatic model_next(output logic [31:0] npc, output logic [31:0] nepc,
                              output int nmode, output int nboot, output bit nmis);
        logic [31:0] tgt;
        npc = m_pc; nepc = m_epc; nmode = m_mode; nboot = m_boot_left; nmis = 1'b0;
        if (m_mode == 0) begin
            npc   = RV;
            nboot = m_boot_left - 1;
            if (nboot <= 0) nmode = 1;
        end else if (m_mode == 1) begin
            if (trap) begin
                nepc = m_pc; npc = TV;
            end else if (trap_ret || jump || branch_taken) begin
                tgt = trap_ret ? m_epc : (jump ? jump_target : branch_target);
                if (ALIGN && (tgt % INC) != 0) begin
                    nepc = m_pc; npc = TV; nmis = 1'b1;
                end else begin
                    npc = tgt;
                end
            end else if (halt_req) begin
                nmode = 2;
            end else if (!stall) begin
                npc = m_pc + INC;
            end
        end else begin
            if (trap) begin
                nepc = m_pc; npc = TV; nmode = 1;
            end else if (resume) begin
                nmode = 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] npc, nepc;
        int nmode, nboot;
        bit nmis;
        if (!rst_n) begin
            m_mode = 0; m_boot_left = BOOT_CYCLES; m_pc = RV; m_epc = '0; m_mis = 1'b0;
        end else begin
            model_next(npc, nepc, nmode, nboot, nmis);
            m_pc = npc; m_epc = nepc; m_mode = nmode; m_boot_left = nboot; m_mis = nmis;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] npc, nepc;
        int nmode, nboot;
        bit nmis;
        chk("m_pc_out",   pc_out,            m_pc);
        chk("m_epc",      epc,               m_epc);
        chk("m_state",    32'(state),        32'(m_mode));
        chk("m_pc_valid", 32'(pc_valid),     32'(m_mode == 1));
        chk("m_misalign", 32'(misalign),     32'(m_mis));
        if (rst_n) begin
            model_next(npc, nepc, nmode, nboot, nmis);
            chk("m_pc_next", pc_next, npc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d: pc_out=%h epc=%h state=%0d valid=%0d misalign=%0d",
                 cyc, pc_out, epc, state, pc_valid, misalign);
    endtask

    task automatic clr();
        stall = 0; branch_taken = 0; jump = 0; trap = 0;
        trap_ret = 0; halt_req = 0; resume = 0;
    endtask

    initial begin
        repeat (3) step();
        chk("rst_pc",    pc_out, 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(pc_valid), 32'd0);
        chk("rst_epc",   epc, 32'h0);
        rst_n = 1;

        // BOOT: two edges, still invalid after the first.
        step(); chk("boot1_valid", 32'(pc_valid), 32'd0); chk("boot1_pc", pc_out, 32'h0);
        step(); chk("boot2_valid", 32'(pc_valid), 32'd1); chk("boot2_pc", pc_out, 32'h0);
        step(); chk("seq_4", pc_out, 32'h4);
        step(); chk("seq_8", pc_out, 32'h8);
        step(); chk("seq_c", pc_out, 32'hC);
        step(); chk("seq_10", pc_out, 32'h10);

        // Stall, then stall + branch.
        stall = 1;
        step(); chk("stall1", pc_out, 32'h10);
        step(); chk("stall2", pc_out, 32'h10);
        branch_taken = 1; branch_target = 32'h40;
        step(); chk("stall_branch", pc_out, 32'h40);
        clr();

        // Priority: trap beats jump and branch; then trap return.
        jump = 1; jump_target = 32'h20;
        step(); chk("jump_20", pc_out, 32'h20);
        clr();
        trap = 1; jump = 1; jump_target = 32'h80; branch_taken = 1; branch_target = 32'h40;
        step(); chk("trap_pc", pc_out, 32'h100); chk("trap_epc", epc, 32'h20);
        clr(); trap_ret = 1;
        step(); chk("tret_pc", pc_out, 32'h20);
        clr();
        step(); chk("tret_seq", pc_out, 32'h24);

        // Wrap-around.
        jump = 1; jump_target = 32'hFFFF_FFF8;
        step(); chk("wrap0", pc_out, 32'hFFFF_FFF8);
        clr();
        step(); chk("wrap1", pc_out, 32'hFFFF_FFFC);
        step(); chk("wrap2", pc_out, 32'h0);

        // Halt and resume.
        jump = 1; jump_target = 32'h30;
        step(); clr();
        halt_req = 1;
        step(); chk("halt_state", 32'(state), 32'd2); chk("halt_valid", 32'(pc_valid), 32'd0);
        clr();
        for (int i = 0; i < 5; i++) begin
            jump = (i == 2); jump_target = 32'h80; stall = (i == 3);
            step(); chk("halt_hold", pc_out, 32'h30);
        end
        clr(); resume = 1;
        step(); chk("resume_state", 32'(state), 32'd1); chk("resume_pc", pc_out, 32'h30);
        clr();
        step(); chk("resume_seq", pc_out, 32'h34);
        halt_req = 1;
        step(); chk("halt2_state", 32'(state), 32'd2); chk("halt2_pc", pc_out, 32'h34);
        clr(); trap = 1; resume = 1;
        step(); chk("htrap_pc", pc_out, 32'h100); chk("htrap_epc", epc, 32'h34);
        chk("htrap_state", 32'(state), 32'd1);
        clr();

        // halt_req losing to a jump is dropped.
        halt_req = 1; jump = 1; jump_target = 32'h200;
        step(); chk("hdrop_pc", pc_out, 32'h200); chk("hdrop_state", 32'(state), 32'd1);
        clr();
        step(); chk("hdrop_seq", pc_out, 32'h204);

        // Misaligned jump target.
        jump = 1; jump_target = 32'h50;
        step(); clr();
        jump = 1; jump_target = 32'h62;
        step();
        if (ALIGN) begin
            chk("mis_pc", pc_out, 32'h100); chk("mis_epc", epc, 32'h50);
            chk("mis_flag", 32'(misalign), 32'd1);
        end else begin
            chk("mis_pc", pc_out, 32'h62); chk("mis_flag", 32'(misalign), 32'd0);
        end
        clr();
        step(); chk("mis_clear", 32'(misalign), 32'd0);

        // Asynchronous reset between edges.
        step();
        #2 rst_n = 0;
        #1;
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_valid", 32'(pc_valid), 32'd0);
        step(); step();
        rst_n = 1;
        step(); step(); chk("rerun_pc", pc_out, 32'h0); chk("rerun_valid", 32'(pc_valid), 32'd1);
        step(); chk("rerun_seq", pc_out, 32'h4);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the plain pc_in → pc_out program counter register in the fetch stage.
- Generates the fetch address itself: reset vector, sequential increment, branch/jump redirect, trap entry/return, stall and halt/resume.
- Sits between the control/branch unit and instruction memory; pc_out drives the instruction memory address.

Parameters:
XLEN, 32, address width in bits
RESET_VECTOR, 32'h0000_0000, pc_out value during reset and BOOT
TRAP_VECTOR, 32'h0000_0100, pc loaded on trap entry
INC, 4, sequential increment in bytes; power of two, at least 1
BOOT_CYCLES, 2, cycles held in BOOT after reset release; at least 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  freeze sequential increment
branch_taken  in  1  redirect to branch_target
branch_target  in  XLEN  branch destination
jump  in  1  redirect to jump_target
jump_target  in  XLEN  jump destination
trap  in  1  trap request
trap_ret  in  1  return from trap to epc
halt_req  in  1  request halt
resume  in  1  leave HALT
pc_out  out  XLEN  current fetch address (registered)
pc_next  out  XLEN  combinational value pc_out takes at the next edge
pc_valid  out  1  pc_out is a valid fetch address this cycle
epc  out  XLEN  saved exception pc (registered)
state  out  2  BOOT=0, RUN=1, HALT=2
misalign  out  1  misaligned-target flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0, acts immediately): pc_out=RESET_VECTOR, epc=0, state=BOOT, pc_valid=0, misalign=0, boot counter=0.
- BOOT
  - pc_out holds RESET_VECTOR; pc_valid=0; all inputs ignored.
  - Counter increments each edge; after BOOT_CYCLES edges, state goes to RUN with pc_out still RESET_VECTOR.
- RUN: pc_valid=1. Each edge applies the highest-priority event:
  1. trap: epc<=pc_out, pc<=TRAP_VECTOR.
  2. trap_ret: pc<=epc.
  3. jump: pc<=jump_target.
  4. branch_taken: pc<=branch_target.
  5. halt_req: state<=HALT, pc holds.
  6. stall: pc holds.
  7. otherwise: pc<=pc_out+INC.
- Redirect and stall interaction: redirects (1–4) override stall and halt_req. A halt_req lost to a higher-priority event is dropped; the requester must re-assert it.
- Sequential add wraps modulo 2^XLEN (0xFFFF_FFFC+4 → 0x0000_0000); no carry-out or flag.
- HALT
  - pc_valid=0; pc_out holds.
  - resume → RUN, pc unchanged.
  - trap → takes trap (epc<=pc_out, pc<=TRAP_VECTOR) and enters RUN; trap wins over resume.
  - All other inputs are ignored.
- pc_next always equals the value pc_out will load at the next edge, including in BOOT and HALT.
- Latency: one cycle from any event to the new pc_out; no bubbles inserted by this block.
- Reset asserted mid-operation: immediate return to reset values; any pending epc/halt state is lost.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A jump, branch or trap_ret target with target[log2(INC)-1:0]≠0 is not taken.
  - Instead: epc<=pc_out, pc<=TRAP_VECTOR, misalign=1 for exactly one cycle (the cycle after the edge).
  - Priority is unchanged: the check applies only to the winning event.
- Undefined: targets are loaded unmodified; misalign is tied 0.

Test Plan:
- Reset then run: rst_n low 3 cycles, release → pc_out=0x0 with pc_valid=0 for 2 edges, then pc_valid=1 and pc_out=0x0, 0x4, 0x8, 0xC on successive edges.
- Stall and branch together: at pc_out=0x10 assert stall 2 cycles → holds 0x10; then stall=1 with branch_taken=1, branch_target=0x40 → next pc_out=0x40.
- Priority and trap return: at pc_out=0x20 assert trap, jump (jump_target=0x80) and branch together → pc_out=0x100, epc=0x20; then trap_ret=1 → pc_out=0x20; next edge → 0x24.
- Wrap-around: jump_target=0xFFFF_FFF8 → pc_out sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Halt and wake: halt_req at pc_out=0x30 → state=HALT, pc_valid=0, pc holds 0x30 for 5 cycles; resume → RUN, next pc_out=0x34. Halt again, then assert trap+resume together → pc_out=0x100, epc=0x34 (the held halt pc), state=RUN.
- PC_ALIGN_CHECK_EN, async reset: with the macro defined, at pc_out=0x50 jump_target=0x62 → pc_out=0x100, epc=0x50, misalign high one cycle. Assert rst_n=0 mid-RUN between edges → pc_out=0x0, state=BOOT before the next clock edge.
